fetch_stall_ctrl: RTL and testbench
===================================

Name: fetch_stall_ctrl

Overview:
- Downstream consumer of the hazard FSM outputs (resolved, pc_freeze, do_flush).
- Owns the program counter and the IF/ID pipeline register.
- Applies stalls (hold), flushes (bubble insertion plus PC redirect) and a stall watchdog.
- Optionally keeps saturating performance counters for stall and flush activity.

Parameters:
- PC_W, 8, program counter width; PC wraps modulo 2^PC_W.
- INSTR_W, 16, fetched instruction width.
- CNT_W, 8, width of perf counters (saturating).
- STALL_MAX, 15, consecutive frozen cycles before stall_timeout asserts; legal range 1..2^CNT_W-1.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- pc_freeze  input  1  hold PC and IF/ID (from hazard FSM)
- do_flush  input  1  squash IF/ID and redirect PC (from hazard FSM)
- resolved  input  1  hazard FSM in normal state
- redirect_pc  input  PC_W  branch-correct target, sampled when do_flush=1
- instr_in  input  INSTR_W  instruction fetched at pc_out
- instr_valid_in  input  1  instr_in is valid this cycle
- pc_out  output  PC_W  current fetch address
- fetch_req  output  1  fetch enable to instruction memory
- ifid_instr  output  INSTR_W  IF/ID instruction
- ifid_pc  output  PC_W  PC of ifid_instr
- ifid_valid  output  1  IF/ID holds a live instruction
- stall_timeout  output  1  freeze run length >= STALL_MAX
- proto_err  output  1  sticky: illegal input combination seen
- stall_cnt  output  CNT_W  frozen-cycle count
- flush_cnt  output  CNT_W  flush count

Behaviour:
- Reset (rst_n=0 at a clk edge) overrides everything:
  - pc_out=0, ifid_instr=0, ifid_pc=0, ifid_valid=0.
  - stall_timeout=0, proto_err=0, counters=0, state=RUN, freeze run counter=0.
- States: RUN, STALL, REDIRECT. Input priority in every state: do_flush > pc_freeze > advance.
- Advance action:
  - pc <= pc+1 (wraps 2^PC_W-1 -> 0).
  - ifid_instr <= instr_in, ifid_pc <= pc, ifid_valid <= instr_valid_in.
- Any state with do_flush=1:
  - pc <= redirect_pc, ifid_valid <= 0.
  - ifid_instr and ifid_pc are left unchanged (don't-care).
  - Next state REDIRECT. pc_freeze is ignored that cycle.
- RUN:
  - pc_freeze=1 -> hold pc and all IF/ID fields, go STALL.
  - Otherwise advance, stay RUN.
- STALL:
  - pc_freeze=1 -> hold, stay STALL.
  - pc_freeze=0 -> advance in the same cycle, go RUN. Single-cycle release latency.
- REDIRECT (exactly one bubble cycle):
  - ifid_valid <= 0, pc held at target.
  - Next state RUN, or STALL if pc_freeze=1.
  - Repeated do_flush reloads redirect_pc and stays in REDIRECT.
- fetch_req is combinational: 1 when do_flush=1 or pc_freeze=0, else 0.
- Watchdog:
  - Run counter increments (saturating) each cycle pc_freeze=1 && do_flush=0; clears to 0 otherwise.
  - stall_timeout is registered: it is 1 on the cycle after the counter reaches STALL_MAX.
  - stall_timeout clears the cycle after the run counter clears.
- proto_err is set sticky (until reset) on any cycle where:
  - resolved=1 with pc_freeze=1 or do_flush=1, or
  - do_flush=1 with pc_freeze=0.
  - Flagging only; pipeline behaviour still follows the priority rules above.
- Mid-operation reset in any state returns to RUN with all reset values on the next edge.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - stall_cnt increments (saturating at 2^CNT_W-1) each cycle pc_freeze=1 && do_flush=0.
  - flush_cnt increments (saturating) each cycle do_flush=1.
- Undefined: no counter flops; stall_cnt and flush_cnt are tied to 0.

Test Plan:
- Reset then 4 cycles advancing, instr_in=0xA000+cycle, instr_valid_in=1 -> pc_out 0,1,2,3,4; ifid_pc lags pc by one; ifid_valid=1.
- At pc=5, pc_freeze=1 for 3 cycles, then 0 -> pc_out stays 5 for 3 cycles and IF/ID is held; fetch_req=0 for 3 cycles; 6 on release cycle+1; with FETCH_PERF_CNT_EN, stall_cnt=3.
- do_flush=1 with pc_freeze=1, redirect_pc=0x40 -> next cycle pc_out=0x40, ifid_valid=0, state REDIRECT; following cycle ifid_valid=0 (bubble), then pc_out=0x41 and ifid_pc=0x40 one cycle later; flush_cnt=1.
- PC wrap, PC_W=8: redirect_pc=0xFF then advance -> pc_out 0xFF -> 0x00; ifid_pc=0xFF.
- pc_freeze held 20 cycles, STALL_MAX=15 -> stall_timeout rises on the cycle after the 15th frozen cycle; falls the cycle after pc_freeze drops plus one; counters saturate correctly when CNT_W=4 and freeze is held 20 cycles.
- resolved=1 with pc_freeze=1 for one cycle, then rst_n=0 mid-STALL -> proto_err=1 sticky until reset; after reset all outputs are 0 and the state is RUN.

Source files
------------

// File: rtl/fetch_stall_ctrl_if.sv
// Fetch-stage control bundle between the hazard FSM / instruction memory side
// and the fetch stall controller.
//
// Handshake semantics: there is no backpressure path. fetch_req is a request
// qualifier for the instruction memory; instr_in is only captured into IF/ID
// on an advance cycle, and instr_valid_in marks whether that captured word is
// live. pc_freeze/do_flush/resolved are level signals sampled every clock.
interface fetch_stall_ctrl_if #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 16,
   parameter int CNT_W   = 8
);
   logic               pc_freeze;
   logic               do_flush;
   logic               resolved;
   logic [PC_W-1:0]    redirect_pc;
   logic [INSTR_W-1:0] instr_in;
   logic               instr_valid_in;

   logic [PC_W-1:0]    pc_out;
   logic               fetch_req;
   logic [INSTR_W-1:0] ifid_instr;
   logic [PC_W-1:0]    ifid_pc;
   logic               ifid_valid;
   logic               stall_timeout;
   logic               proto_err;
   logic [CNT_W-1:0]   stall_cnt;
   logic [CNT_W-1:0]   flush_cnt;
   logic [1:0]         dbg_state;

   modport master (
      output pc_freeze, do_flush, resolved, redirect_pc, instr_in, instr_valid_in,
      input  pc_out, fetch_req, ifid_instr, ifid_pc, ifid_valid,
             stall_timeout, proto_err, stall_cnt, flush_cnt, dbg_state
   );

   modport slave (
      input  pc_freeze, do_flush, resolved, redirect_pc, instr_in, instr_valid_in,
      output pc_out, fetch_req, ifid_instr, ifid_pc, ifid_valid,
             stall_timeout, proto_err, stall_cnt, flush_cnt, dbg_state
   );
endinterface

// File: rtl/fetch_stall_ctrl.sv
// Fetch stall controller: owns the PC and the IF/ID register, applies
// stalls, flushes (bubble + redirect) and a freeze-run watchdog.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/flush counters;
// without it stall_cnt/flush_cnt read as 0 and no counter flops exist.
// dbg_state exposes the FSM state: 0=RUN, 1=STALL, 2=REDIRECT.
module fetch_stall_ctrl #(
   parameter int PC_W      = 8,
   parameter int INSTR_W   = 16,
   parameter int CNT_W     = 8,
   parameter int STALL_MAX = 15
) (
   input logic              clk,
   input logic              rst_n,
   fetch_stall_ctrl_if.slave fsc_if
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_STALL    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
   logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
   logic               ifid_valid_q, ifid_valid_d;
   logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
   logic               timeout_q, timeout_d;
   logic               proto_q, proto_d;
   logic               frozen;

   // A cycle counts as frozen only when no flush overrides the freeze.
   assign frozen = fsc_if.pc_freeze & ~fsc_if.do_flush;

   // Next-state and pipeline update; priority do_flush > pc_freeze > advance.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_valid_d = ifid_valid_q;
      if (fsc_if.do_flush) begin
         // IF/ID instr/pc are left as-is; only the valid bit matters.
         pc_d         = fsc_if.redirect_pc;
         ifid_valid_d = 1'b0;
         state_d      = ST_REDIRECT;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (fsc_if.pc_freeze) begin
                  state_d = ST_STALL;
               end else begin
                  pc_d         = pc_q + PC_W'(1);
                  ifid_instr_d = fsc_if.instr_in;
                  ifid_pc_d    = pc_q;
                  ifid_valid_d = fsc_if.instr_valid_in;
               end
            end
            ST_STALL: begin
               if (!fsc_if.pc_freeze) begin
                  // Release advances in the same cycle.
                  pc_d         = pc_q + PC_W'(1);
                  ifid_instr_d = fsc_if.instr_in;
                  ifid_pc_d    = pc_q;
                  ifid_valid_d = fsc_if.instr_valid_in;
                  state_d      = ST_RUN;
               end
            end
            ST_REDIRECT: begin
               // One bubble while the PC sits on the redirect target.
               ifid_valid_d = 1'b0;
               state_d      = fsc_if.pc_freeze ? ST_STALL : ST_RUN;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   // Watchdog run counter, registered timeout and sticky protocol error.
   always_comb begin
      run_cnt_d = '0;
      if (frozen) begin
         run_cnt_d = (run_cnt_q == {CNT_W{1'b1}}) ? run_cnt_q : run_cnt_q + CNT_W'(1);
      end
      // Timeout follows the registered run count, so it lags it by one cycle.
      timeout_d = (run_cnt_q >= CNT_W'(STALL_MAX));
      proto_d   = proto_q
                | (fsc_if.resolved & (fsc_if.pc_freeze | fsc_if.do_flush))
                | (fsc_if.do_flush & ~fsc_if.pc_freeze);
   end

   // State and pipeline registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         pc_q         <= '0;
         ifid_instr_q <= '0;
         ifid_pc_q    <= '0;
         ifid_valid_q <= 1'b0;
         run_cnt_q    <= '0;
         timeout_q    <= 1'b0;
         proto_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_valid_q <= ifid_valid_d;
         run_cnt_q    <= run_cnt_d;
         timeout_q    <= timeout_d;
         proto_q      <= proto_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Saturating activity counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (frozen && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (fsc_if.do_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign fsc_if.stall_cnt = stall_cnt_q;
   assign fsc_if.flush_cnt = flush_cnt_q;
`else
   assign fsc_if.stall_cnt = '0;
   assign fsc_if.flush_cnt = '0;
`endif

   assign fsc_if.fetch_req     = fsc_if.do_flush | ~fsc_if.pc_freeze;
   assign fsc_if.pc_out        = pc_q;
   assign fsc_if.ifid_instr    = ifid_instr_q;
   assign fsc_if.ifid_pc       = ifid_pc_q;
   assign fsc_if.ifid_valid    = ifid_valid_q;
   assign fsc_if.stall_timeout = timeout_q;
   assign fsc_if.proto_err     = proto_q;
   assign fsc_if.dbg_state     = state_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl: reset, advance, stall, flush/redirect,
// PC wrap, watchdog, protocol error and mid-stall reset. A second instance
// with CNT_W=4 shares the stimulus to exercise counter saturation.
module tb_fetch_stall_ctrl;

   localparam logic [1:0] S_RUN = 2'd0;
   localparam logic [1:0] S_STALL = 2'd1;
   localparam logic [1:0] S_REDIR = 2'd2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fetch_stall_ctrl_if #(.PC_W(8), .INSTR_W(16), .CNT_W(8)) f ();
   fetch_stall_ctrl_if #(.PC_W(8), .INSTR_W(16), .CNT_W(4)) g ();

   fetch_stall_ctrl #(.PC_W(8), .INSTR_W(16), .CNT_W(8), .STALL_MAX(15)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .fsc_if (f.slave)
   );

   fetch_stall_ctrl #(.PC_W(8), .INSTR_W(16), .CNT_W(4), .STALL_MAX(15)) u_dut4 (
      .clk    (clk),
      .rst_n  (rst_n),
      .fsc_if (g.slave)
   );

   assign g.pc_freeze      = f.pc_freeze;
   assign g.do_flush       = f.do_flush;
   assign g.resolved       = f.resolved;
   assign g.redirect_pc    = f.redirect_pc;
   assign g.instr_in       = f.instr_in;
   assign g.instr_valid_in = f.instr_valid_in;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic frz, input logic fl, input logic res,
                        input logic [7:0] rpc, input logic [15:0] ins, input logic iv);
      f.pc_freeze      = frz;
      f.do_flush       = fl;
      f.resolved       = res;
      f.redirect_pc    = rpc;
      f.instr_in       = ins;
      f.instr_valid_in = iv;
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected perf counter value: saturated when the feature is built, else 0.
   function automatic logic [31:0] cnt_exp(input int v, input int maxv);
`ifdef FETCH_PERF_CNT_EN
      return (v > maxv) ? maxv : v;
`else
      return 0;
`endif
   endfunction

   initial begin
      // Reset
      drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_pc", f.pc_out, 0);
      check("rst_ifid_instr", f.ifid_instr, 0);
      check("rst_ifid_pc", f.ifid_pc, 0);
      check("rst_ifid_valid", f.ifid_valid, 0);
      check("rst_timeout", f.stall_timeout, 0);
      check("rst_proto", f.proto_err, 0);
      check("rst_state", f.dbg_state, S_RUN);
      check("rst_stall_cnt", f.stall_cnt, 0);
      check("rst_flush_cnt", f.flush_cnt, 0);

      // Advance five cycles: pc 0..4 -> 5, IF/ID lags by one
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'h00, 16'hA000 + 16'(i), 1'b1);
         check("adv_pc_before", f.pc_out, i);
         check("adv_fetch_req", f.fetch_req, 1);
         tick();
         check("adv_pc_after", f.pc_out, i + 1);
         check("adv_ifid_pc", f.ifid_pc, i);
         check("adv_ifid_instr", f.ifid_instr, 32'hA000 + i);
         check("adv_ifid_valid", f.ifid_valid, 1);
      end

      // Freeze for three cycles at pc=5
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 8'h00, 16'hEEEE, 1'b1);
         check("stall_fetch_req", f.fetch_req, 0);
         tick();
         check("stall_pc", f.pc_out, 5);
         check("stall_ifid_pc", f.ifid_pc, 4);
         check("stall_ifid_instr", f.ifid_instr, 32'hA004);
         check("stall_state", f.dbg_state, S_STALL);
      end
      // Release advances in the same cycle
      drive(1'b0, 1'b0, 1'b1, 8'h00, 16'hA005, 1'b1);
      check("rel_fetch_req", f.fetch_req, 1);
      tick();
      check("rel_pc", f.pc_out, 6);
      check("rel_ifid_pc", f.ifid_pc, 5);
      check("rel_ifid_instr", f.ifid_instr, 32'hA005);
      check("rel_state", f.dbg_state, S_RUN);
      check("rel_stall_cnt", f.stall_cnt, cnt_exp(3, 255));
      check("rel_timeout", f.stall_timeout, 0);

      // Flush with freeze: redirect to 0x40, one bubble, then advance
      drive(1'b1, 1'b1, 1'b0, 8'h40, 16'hEEEE, 1'b1);
      check("flush_fetch_req", f.fetch_req, 1);
      tick();
      check("flush_pc", f.pc_out, 8'h40);
      check("flush_valid", f.ifid_valid, 0);
      check("flush_state", f.dbg_state, S_REDIR);
      check("flush_cnt1", f.flush_cnt, cnt_exp(1, 255));
      check("flush_stall_cnt", f.stall_cnt, cnt_exp(3, 255));
      check("flush_proto", f.proto_err, 0);
      drive(1'b0, 1'b0, 1'b1, 8'h00, 16'hB000, 1'b1);
      tick();
      check("bubble_pc", f.pc_out, 8'h40);
      check("bubble_valid", f.ifid_valid, 0);
      check("bubble_state", f.dbg_state, S_RUN);
      drive(1'b0, 1'b0, 1'b1, 8'h00, 16'hB040, 1'b1);
      tick();
      check("post_redir_pc", f.pc_out, 8'h41);
      check("post_redir_ifid_pc", f.ifid_pc, 8'h40);
      check("post_redir_instr", f.ifid_instr, 32'hB040);
      check("post_redir_valid", f.ifid_valid, 1);

      // PC wrap: redirect to 0xFF then advance
      drive(1'b1, 1'b1, 1'b0, 8'hFF, 16'hEEEE, 1'b1);
      tick();
      check("wrap_redir_pc", f.pc_out, 8'hFF);
      drive(1'b0, 1'b0, 1'b1, 8'h00, 16'hEEEE, 1'b1);
      tick();
      check("wrap_bubble_pc", f.pc_out, 8'hFF);
      drive(1'b0, 1'b0, 1'b1, 8'h00, 16'hC0FF, 1'b1);
      tick();
      check("wrap_pc", f.pc_out, 8'h00);
      check("wrap_ifid_pc", f.ifid_pc, 8'hFF);
      check("wrap_ifid_instr", f.ifid_instr, 32'hC0FF);

      // Back-to-back flushes stay in REDIRECT and reload the target
      drive(1'b1, 1'b1, 1'b0, 8'h10, 16'hEEEE, 1'b1);
      tick();
      check("rep1_pc", f.pc_out, 8'h10);
      drive(1'b1, 1'b1, 1'b0, 8'h20, 16'hEEEE, 1'b1);
      tick();
      check("rep2_pc", f.pc_out, 8'h20);
      check("rep2_state", f.dbg_state, S_REDIR);
      check("rep2_flush_cnt", f.flush_cnt, cnt_exp(4, 255));

      // Freeze 20 cycles from REDIRECT: watchdog rises after the 16th edge
      for (int k = 1; k <= 20; k++) begin
         drive(1'b1, 1'b0, 1'b0, 8'h00, 16'hEEEE, 1'b1);
         tick();
         if (k == 1) begin
            check("wd_state", f.dbg_state, S_STALL);
            check("wd_pc", f.pc_out, 8'h20);
            check("wd_valid", f.ifid_valid, 0);
         end
         if (k == 15) check("wd_timeout_15", f.stall_timeout, 0);
         if (k == 16) check("wd_timeout_16", f.stall_timeout, 1);
         if (k == 16) check("wd4_timeout_16", g.stall_timeout, 1);
      end
      check("wd_timeout_20", f.stall_timeout, 1);
      check("wd_stall_cnt", f.stall_cnt, cnt_exp(23, 255));
      check("wd4_stall_cnt_sat", g.stall_cnt, cnt_exp(23, 15));
      check("wd4_flush_cnt", g.flush_cnt, cnt_exp(4, 15));
      // Release: timeout still high one cycle, then clears
      drive(1'b0, 1'b0, 1'b1, 8'h00, 16'hD020, 1'b1);
      tick();
      check("wd_rel_pc", f.pc_out, 8'h21);
      check("wd_rel_ifid_pc", f.ifid_pc, 8'h20);
      check("wd_rel_timeout", f.stall_timeout, 1);
      drive(1'b0, 1'b0, 1'b1, 8'h00, 16'hD021, 1'b1);
      tick();
      check("wd_clr_timeout", f.stall_timeout, 0);
      check("wd4_clr_timeout", g.stall_timeout, 0);
      check("wd_clr_pc", f.pc_out, 8'h22);
      check("pre_proto", f.proto_err, 0);

      // Protocol error: resolved with freeze, then reset mid-STALL
      drive(1'b1, 1'b0, 1'b1, 8'h00, 16'hEEEE, 1'b1);
      tick();
      check("proto_set", f.proto_err, 1);
      check("proto_state", f.dbg_state, S_STALL);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 16'hEEEE, 1'b1);
      tick();
      check("proto_sticky", f.proto_err, 1);
      rst_n = 1'b0;
      tick();
      check("mid_rst_pc", f.pc_out, 0);
      check("mid_rst_ifid_pc", f.ifid_pc, 0);
      check("mid_rst_ifid_instr", f.ifid_instr, 0);
      check("mid_rst_valid", f.ifid_valid, 0);
      check("mid_rst_proto", f.proto_err, 0);
      check("mid_rst_timeout", f.stall_timeout, 0);
      check("mid_rst_state", f.dbg_state, S_RUN);
      check("mid_rst_stall_cnt", f.stall_cnt, 0);
      check("mid_rst_flush_cnt", f.flush_cnt, 0);
      check("mid_rst_fetch_req", f.fetch_req, 0);

      // Flush without freeze is also a protocol error
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 8'h33, 16'hEEEE, 1'b1);
      tick();
      check("proto_flush_nofrz", f.proto_err, 1);
      check("proto_flush_pc", f.pc_out, 8'h33);
      check("proto_flush_state", f.dbg_state, S_REDIR);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
